// File: rtl/clkdiv_pkg.sv
// Shared types for the programmable clock divider: channel state and channel-index width.
// Optional build macro used across this block: CLKDIV_TICK_EN (adds per-channel rising-edge tick).
package clkdiv_pkg;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_RUN      = 2'd1,
      ST_RUN_PEND = 2'd2
   } chan_state_e;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clock_divider_prog_if.sv
// Configuration write channel of the divider: valid/ready handshake plus error pulse.
// The divider is the slave; the configuring agent is the master.
interface clock_divider_prog_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 28
);
   localparam int CH_W = clkdiv_pkg::ch_w(CHANNELS);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_err;

   modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: half-period counter with a shadow register committed only at a toggle.
// With CLKDIV_TICK_EN defined, also emits a one-cycle tick on each rising edge of clk_div.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int CNT_W    = 28,
   parameter int RST_HALF = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_half,
   output logic             pend,
`ifdef CLKDIV_TICK_EN
   output logic             tick,
`endif
   output logic             clk_div
);

   chan_state_e      state_q;
   logic [CNT_W-1:0] ctr_q;
   logic [CNT_W-1:0] half_act_q;
   logic [CNT_W-1:0] half_shd_q;
   logic             clk_q;
   logic             boundary_s;

   assign boundary_s = (ctr_q == half_act_q);
   assign pend       = (state_q == ST_RUN_PEND);
   assign clk_div    = clk_q;

   // Channel FSM, counter and active/shadow half-period registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_OFF;
         ctr_q      <= '0;
         half_act_q <= CNT_W'(RST_HALF);
         half_shd_q <= CNT_W'(RST_HALF);
         clk_q      <= 1'b0;
      end else if (!en) begin
         // Stopping commits any pending shadow value so OFF always holds the latest write
         state_q <= ST_OFF;
         ctr_q   <= '0;
         clk_q   <= 1'b0;
         if (wr) begin
            half_shd_q <= wr_half;
            half_act_q <= wr_half;
         end else begin
            half_act_q <= half_shd_q;
         end
      end else begin
         case (state_q)
            ST_OFF: begin
               state_q <= ST_RUN;
               ctr_q   <= '0;
               clk_q   <= 1'b0;
               if (wr) begin
                  half_shd_q <= wr_half;
                  half_act_q <= wr_half;
               end
            end
            ST_RUN, ST_RUN_PEND: begin
               if (boundary_s) begin
                  ctr_q <= '0;
                  clk_q <= ~clk_q;
               end else begin
                  ctr_q <= ctr_q + CNT_W'(1);
               end
               // A write landing on a boundary only arms the shadow; it takes effect one boundary later
               if ((state_q == ST_RUN_PEND) && boundary_s) begin
                  half_act_q <= half_shd_q;
                  state_q    <= ST_RUN;
               end else if ((state_q == ST_RUN) && wr) begin
                  half_shd_q <= wr_half;
                  state_q    <= ST_RUN_PEND;
               end
            end
            default: begin
               state_q <= ST_OFF;
               ctr_q   <= '0;
               clk_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef CLKDIV_TICK_EN
   logic tick_q;

   // Tick registers alongside clk_q on every 0->1 toggle
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_q <= 1'b0;
      end else if (en && (state_q != ST_OFF) && boundary_s && !clk_q) begin
         tick_q <= 1'b1;
      end else begin
         tick_q <= 1'b0;
      end
   end

   assign tick = tick_q;
`endif

endmodule

// File: rtl/clock_divider_prog.sv
// Programmable multi-channel clock divider: config decode, ready/error handling, channel array.
// Optional build macro: CLKDIV_TICK_EN adds the per-channel tick output.
module clock_divider_prog
   import clkdiv_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 28,
   parameter int RST_HALF = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   clock_divider_prog_if.slave cfg,
`ifdef CLKDIV_TICK_EN
   output logic [CHANNELS-1:0] tick,
`endif
   output logic [CHANNELS-1:0] clk_div
);

   localparam int            CH_W   = ch_w(CHANNELS);
   localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

   logic                  oor_s;
   logic [2**CH_W-1:0]    pend_ext_s;
   logic [CHANNELS-1:0]   pend_s;
   logic [CHANNELS-1:0]   wr_s;
   logic                  cfg_err_q;

   // Ready is blocked only while the addressed channel holds an uncommitted value
   always_comb begin
      oor_s                       = ({1'b0, cfg.cfg_ch} >= CH_LIM);
      pend_ext_s                  = '0;
      pend_ext_s[CHANNELS-1:0]    = pend_s;
      if (oor_s) begin
         cfg.cfg_ready = 1'b1;
      end else begin
         cfg.cfg_ready = ~pend_ext_s[cfg.cfg_ch];
      end
   end

   // Error flag for accepted writes to a non-existent channel
   always_ff @(posedge clk) begin
      if (!rst) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg.cfg_valid & oor_s;
      end
   end

   assign cfg.cfg_err = cfg_err_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign wr_s[i] = cfg.cfg_valid & cfg.cfg_ready & ~oor_s & (cfg.cfg_ch == CH_W'(i));

      clkdiv_chan #(
         .CNT_W    (CNT_W),
         .RST_HALF (RST_HALF)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .en      (en[i]),
         .wr      (wr_s[i]),
         .wr_half (cfg.cfg_half),
         .pend    (pend_s[i]),
`ifdef CLKDIV_TICK_EN
         .tick    (tick[i]),
`endif
         .clk_div (clk_div[i])
      );
   end

endmodule
